interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Interrupt request controller for the multicycle MIPS core; the request/acknowledge end of the control unit's interrupt handshake. Collects `N_IRQ` external request lines, latches them as pending, applies a software-writable mask, and drives `int_sig` to the control unit. On acknowledge it freezes the winning source, presents its vector address for the PC-source mux, and holds in-service until return-from-exception.

## Interface
- `N_IRQ`, 8: number of request lines, 1..16.
- `VEC_BASE`, 32'h0000_0080: vector address of source 0.
- `VEC_STRIDE`, 32'h0000_0010: byte distance between consecutive source vectors.
- `LEVEL_SRC`, all zeros: `N_IRQ`-bit mask; bit=1 marks the source level-sensitive, 0 edge-sensitive (rising).
- `MASK_RESET`, all ones: mask value after reset; 1 = enabled.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `irq` in `N_IRQ`: request lines, already synchronous to `clk`.
- `int_ack` in 1: acknowledge; connected to the control unit's `int_save_pc`; one-cycle pulse.
- `int_eoi` in 1: end of interrupt; one-cycle pulse while the control unit executes RFE.
- `mask_we` in 1: mask write strobe.
- `mask_wdata` in `N_IRQ`: new mask value.
- `int_sig` out 1: interrupt request to the control unit; registered.
- `int_vector` out 32: handler address; feeds PC-source input 3; registered.
- `int_cause` out 4: index of the source in service; registered.
- `in_service` out 1: a handler is active.
- `pending` out `N_IRQ`: pending register, for debug/status.
- `mask` out `N_IRQ`: current mask.

## Operation
- Reset values: `int_sig`=0, `int_vector`=`VEC_BASE`, `int_cause`=0, `in_service`=0, `pending`=0, `mask`=`MASK_RESET`, state IDLE, `irq_q`=0.
- Edge sources: `pending[i]` set when `irq[i] & ~irq_q[i]`; held until acknowledged.
- Level sources: `pending[i]` follows `irq[i]` every cycle; the ack does not clear it.
- Request vector: `req = pending & mask`. Winner: lowest set index in `req` (fixed priority, 0 highest).
- States:
  - IDLE: `int_sig`=0. If `req`≠0 → REQUEST.
  - REQUEST: `int_sig`=1. On `int_ack`: capture winner into `int_cause`, load `int_vector = VEC_BASE + cause*VEC_STRIDE` (32-bit, wrap ignored), clear winner's pending bit if edge source, set `in_service`, → SERVICE. If `req` becomes 0 with no ack (mask write): → IDLE.
  - SERVICE: `int_sig`=0; `int_vector`/`int_cause` frozen. On `int_eoi`: clear `in_service`, → IDLE (re-requests next cycle if `req`≠0).
- No nesting: new pending bits accumulate during SERVICE but are not requested.
- Simultaneous events: new edge on the winner in the ack cycle → set wins, bit stays pending. `mask_we` with `int_ack` → winner computed from the old mask. `int_ack` outside REQUEST and `int_eoi` outside SERVICE are ignored.
- Reset mid-service: everything returns to reset values; stale `int_eoi` after reset is ignored.

## Timing
- `irq` edge at cycle n → `pending` set at n+1 → `int_sig`=1 at n+2.
- `int_ack` at cycle a → `int_vector`/`int_cause` valid and `int_sig`=0 at a+1, the cycle the control unit's INTERRUPT state loads PC.
- `int_eoi` at cycle e → `in_service`=0 at e+1; if `req`≠0, `int_sig`=1 at e+2.
- Mask write at cycle w takes effect at w+1.

## Structure
- Shared package `irq_pkg`: state encoding (IDLE, REQUEST, SERVICE), `IRQ_MAX`=16, cause width 4, default `VEC_BASE`/`VEC_STRIDE`.
- Sub-module `irq_prio_enc`: combinational lowest-index priority encoder returning `{valid, index}`; reused by a future status register block.
- Top module holds the edge-detect flops, pending/mask registers, FSM and vector arithmetic.

## Test plan
- Edge on `irq[3]`, mask all ones → `int_sig` rises 2 cycles later; ack → `int_cause`=3, `int_vector`=32'h0000_00B0, `pending[3]`=0.
- `irq[5]` and `irq[2]` edges in the same cycle → first ack serves 2; after eoi, `int_sig` returns and the second ack serves 5 (vector 32'h0000_00D0).
- `mask`=8'hFE, edge on `irq[0]` → no `int_sig`; write `mask`=8'hFF → `int_sig` asserts next cycle, cause 0.
- New edge on `irq[4]` during SERVICE of 1 → `int_sig` stays 0 until eoi, then asserts; ack gives cause 4.
- Level source 6 held high through ack and eoi → `pending[6]` stays 1; re-request follows eoi.
- Assert `rst` in SERVICE → next cycle all outputs at reset values; a following `int_eoi` has no effect.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request controller:
// FSM encoding, cause width and default vector layout.
package irq_pkg;

    localparam int IRQ_MAX = 16;
    localparam int CAUSE_W = 4;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0080;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQUEST = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Handler address of a given source; 32-bit wrap is intentional.
    function automatic logic [31:0] vec_addr(
        input logic [31:0]        base,
        input logic [31:0]        stride,
        input logic [CAUSE_W-1:0] cause
    );
        return base + stride * {{(32-CAUSE_W){1'b0}}, cause};
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Request/acknowledge bundle between the interrupt controller,
// the external request lines and the control unit.
interface interrupt_controller_if #(
    parameter int N_IRQ = 8
);
    import irq_pkg::*;

    logic [N_IRQ-1:0]   irq;
    logic               int_ack;
    logic               int_eoi;
    logic               mask_we;
    logic [N_IRQ-1:0]   mask_wdata;
    logic               int_sig;
    logic [31:0]        int_vector;
    logic [CAUSE_W-1:0] int_cause;
    logic               in_service;
    logic [N_IRQ-1:0]   pending;
    logic [N_IRQ-1:0]   mask;

    modport master (
        output irq, int_ack, int_eoi, mask_we, mask_wdata,
        input  int_sig, int_vector, int_cause, in_service, pending, mask
    );

    modport slave (
        input  irq, int_ack, int_eoi, mask_we, mask_wdata,
        output int_sig, int_vector, int_cause, in_service, pending, mask
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, returns {valid, index}.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]       req_i,
    output logic               valid_o,
    output logic [CAUSE_W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last writer.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = i[CAUSE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt request controller: edge/level capture, mask, fixed
// priority, and the request/ack/eoi handshake with the control unit.
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int               N_IRQ      = 8,
    parameter logic [31:0]      VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0]      VEC_STRIDE = VEC_STRIDE_DEF,
    parameter logic [N_IRQ-1:0] LEVEL_SRC  = '0,
    parameter logic [N_IRQ-1:0] MASK_RESET = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    interrupt_controller_if.slave bus
);

    logic [N_IRQ-1:0]   irq_q;
    logic [N_IRQ-1:0]   pending_q, pending_d;
    logic [N_IRQ-1:0]   mask_q, mask_d;
    logic [1:0]         state_q, state_d;
    logic               int_sig_q, int_sig_d;
    logic [31:0]        vector_q, vector_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               in_service_q, in_service_d;

    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   req;
    logic [N_IRQ-1:0]   clr;
    logic               win_valid;
    logic [CAUSE_W-1:0] win_idx;
    logic               take;

    assign rise = bus.irq & ~irq_q;
    assign req  = pending_q & mask_q;

    irq_prio_enc #(
        .N (N_IRQ)
    ) u_prio (
        .req_i   (req),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    // Ack is accepted only in REQUEST and only with a live winner.
    assign take = (state_q == ST_REQUEST) && bus.int_ack && win_valid;

    // Pending: level sources track the line; edge sources set on a
    // rising edge and clear on ack, with a same-cycle edge winning.
    always_comb begin
        clr       = '0;
        pending_d = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            clr[i] = take && (win_idx == i[CAUSE_W-1:0]);
            if (LEVEL_SRC[i]) begin
                pending_d[i] = bus.irq[i];
            end else begin
                pending_d[i] = (pending_q[i] & ~clr[i]) | rise[i];
            end
        end
    end

    // Mask register: the new value is visible the cycle after the write.
    always_comb begin
        mask_d = mask_q;
        if (bus.mask_we) begin
            mask_d = bus.mask_wdata;
        end
    end

    // Handshake FSM with registered int_sig and frozen vector/cause.
    always_comb begin
        state_d      = state_q;
        int_sig_d    = 1'b0;
        vector_d     = vector_q;
        cause_d      = cause_q;
        in_service_d = in_service_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d   = ST_REQUEST;
                    int_sig_d = 1'b1;
                end
            end
            ST_REQUEST: begin
                if (take) begin
                    state_d      = ST_SERVICE;
                    cause_d      = win_idx;
                    vector_d     = vec_addr(VEC_BASE, VEC_STRIDE, win_idx);
                    in_service_d = 1'b1;
                end else if (!win_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    int_sig_d = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (bus.int_eoi) begin
                    state_d      = ST_IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                in_service_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q        <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RESET;
            state_q      <= ST_IDLE;
            int_sig_q    <= 1'b0;
            vector_q     <= VEC_BASE;
            cause_q      <= '0;
            in_service_q <= 1'b0;
        end else begin
            irq_q        <= bus.irq;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            state_q      <= state_d;
            int_sig_q    <= int_sig_d;
            vector_q     <= vector_d;
            cause_q      <= cause_d;
            in_service_q <= in_service_d;
        end
    end

    assign bus.int_sig    = int_sig_q;
    assign bus.int_vector = vector_q;
    assign bus.int_cause  = cause_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: edge/level capture,
// priority, masking, no-nesting and reset-in-service.
module tb_interrupt_controller;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interrupt_controller_if #(.N_IRQ(8)) bus ();

    interrupt_controller #(
        .N_IRQ      (8),
        .VEC_BASE   (32'h0000_0080),
        .VEC_STRIDE (32'h0000_0010),
        .LEVEL_SRC  (8'h40),
        .MASK_RESET (8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        bus.irq = v;
        tick();
        bus.irq = 8'h00;
    endtask

    task automatic ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic eoi();
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
    endtask

    task automatic wmask(input logic [7:0] v);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = v;
        tick();
        bus.mask_we    = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.irq        = 8'h00;
        bus.int_ack    = 1'b0;
        bus.int_eoi    = 1'b0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_sig", 32'(bus.int_sig), 32'd0);
        chk("rst_vec", bus.int_vector, 32'h80);
        chk("rst_cause", 32'(bus.int_cause), 32'd0);
        chk("rst_insvc", 32'(bus.in_service), 32'd0);
        chk("rst_pend", 32'(bus.pending), 32'h00);
        chk("rst_mask", 32'(bus.mask), 32'hFF);

        // Ack outside REQUEST is ignored.
        ack();
        chk("idle_ack", 32'(bus.in_service), 32'd0);

        // Single edge on source 3.
        pulse_irq(8'h08);
        chk("t1_pend", 32'(bus.pending), 32'h08);
        chk("t1_sig0", 32'(bus.int_sig), 32'd0);
        tick();
        chk("t1_sig1", 32'(bus.int_sig), 32'd1);
        ack();
        chk("t1_cause", 32'(bus.int_cause), 32'd3);
        chk("t1_vec", bus.int_vector, 32'hB0);
        chk("t1_pclr", 32'(bus.pending), 32'h00);
        chk("t1_sigack", 32'(bus.int_sig), 32'd0);
        chk("t1_insvc", 32'(bus.in_service), 32'd1);
        eoi();
        chk("t1_eoi", 32'(bus.in_service), 32'd0);
        tick();
        chk("t1_quiet", 32'(bus.int_sig), 32'd0);

        // Two simultaneous edges: 2 then 5.
        pulse_irq(8'h24);
        tick();
        chk("t2_sig", 32'(bus.int_sig), 32'd1);
        ack();
        chk("t2_c2", 32'(bus.int_cause), 32'd2);
        chk("t2_pend", 32'(bus.pending), 32'h20);
        eoi();
        chk("t2_eoi_sig", 32'(bus.int_sig), 32'd0);
        tick();
        chk("t2_rereq", 32'(bus.int_sig), 32'd1);
        ack();
        chk("t2_c5", 32'(bus.int_cause), 32'd5);
        chk("t2_vec5", bus.int_vector, 32'hD0);
        eoi();
        tick();

        // Masked source 0, then unmask.
        wmask(8'hFE);
        chk("t3_mask", 32'(bus.mask), 32'hFE);
        pulse_irq(8'h01);
        tick();
        tick();
        chk("t3_masked", 32'(bus.int_sig), 32'd0);
        chk("t3_pend", 32'(bus.pending), 32'h01);
        wmask(8'hFF);
        chk("t3_mask2", 32'(bus.mask), 32'hFF);
        tick();
        chk("t3_sig", 32'(bus.int_sig), 32'd1);
        ack();
        chk("t3_cause", 32'(bus.int_cause), 32'd0);
        chk("t3_vec", bus.int_vector, 32'h80);
        eoi();
        tick();

        // No nesting: edge on 4 while serving 1.
        pulse_irq(8'h02);
        tick();
        ack();
        chk("t4_c1", 32'(bus.int_cause), 32'd1);
        pulse_irq(8'h10);
        tick();
        tick();
        chk("t4_nonest", 32'(bus.int_sig), 32'd0);
        chk("t4_pend", 32'(bus.pending), 32'h10);
        chk("t4_frozen", 32'(bus.int_cause), 32'd1);
        eoi();
        chk("t4_eoi_sig", 32'(bus.int_sig), 32'd0);
        tick();
        chk("t4_rereq", 32'(bus.int_sig), 32'd1);
        ack();
        chk("t4_c4", 32'(bus.int_cause), 32'd4);
        chk("t4_vec", bus.int_vector, 32'hC0);
        eoi();
        tick();

        // Level source 6 held through ack and eoi.
        bus.irq = 8'h40;
        tick();
        chk("t5_pend", 32'(bus.pending), 32'h40);
        tick();
        chk("t5_sig", 32'(bus.int_sig), 32'd1);
        ack();
        chk("t5_cause", 32'(bus.int_cause), 32'd6);
        chk("t5_vec", bus.int_vector, 32'hE0);
        chk("t5_keep", 32'(bus.pending), 32'h40);
        eoi();
        tick();
        chk("t5_rereq", 32'(bus.int_sig), 32'd1);
        bus.irq = 8'h00;
        tick();
        chk("t5_pdrop", 32'(bus.pending), 32'h00);
        tick();
        chk("t5_withdraw", 32'(bus.int_sig), 32'd0);

        // Edge on the winner in the ack cycle stays pending.
        pulse_irq(8'h08);
        tick();
        bus.irq     = 8'h08;
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.irq     = 8'h00;
        chk("t6_cause", 32'(bus.int_cause), 32'd3);
        chk("t6_setwins", 32'(bus.pending), 32'h08);
        eoi();
        tick();
        chk("t6_rereq", 32'(bus.int_sig), 32'd1);
        ack();
        chk("t6_pclr", 32'(bus.pending), 32'h00);
        eoi();
        tick();

        // Reset during service, then stale eoi.
        pulse_irq(8'h80);
        tick();
        ack();
        chk("t7_c7", 32'(bus.int_cause), 32'd7);
        wmask(8'h0F);
        pulse_irq(8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_sig", 32'(bus.int_sig), 32'd0);
        chk("t7_vec", bus.int_vector, 32'h80);
        chk("t7_cause", 32'(bus.int_cause), 32'd0);
        chk("t7_insvc", 32'(bus.in_service), 32'd0);
        chk("t7_pend", 32'(bus.pending), 32'h00);
        chk("t7_mask", 32'(bus.mask), 32'hFF);
        eoi();
        tick();
        chk("t7_stale_insvc", 32'(bus.in_service), 32'd0);
        chk("t7_stale_sig", 32'(bus.int_sig), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
